alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 157 +++++++++++++++
 tb/tb_alu_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one external 32-bit ALU, with a one-entry response register per requester.
// Build option: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic [2:0]  req0_funct3,
  input  logic        req0_f7b5,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  input  logic [2:0]  req1_funct3,
  input  logic        req1_f7b5,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic [31:0] alu_operand_a,
  output logic [31:0] alu_operand_b,
  output logic [3:0]  alu_op,
  output logic [2:0]  alu_funct3,
  output logic        alu_funct7_bit5,
  input  logic [31:0] alu_result,
  input  logic        alu_is_zero,
  output logic        last_grant
);

  logic        rsp0_valid_q, rsp0_valid_d;
  logic [31:0] rsp0_result_q, rsp0_result_d;
  logic        rsp0_zero_q, rsp0_zero_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp1_result_q, rsp1_result_d;
  logic        rsp1_zero_q, rsp1_zero_d;
  logic        last_grant_q, last_grant_d;
  logic        elig0, elig1;
  logic        grant0, grant1;

  // A requester may issue when its response slot is free or being drained this cycle.
  always_comb begin
    elig0  = req0_valid & (~rsp0_valid_q | rsp0_ready);
    elig1  = req1_valid & (~rsp1_valid_q | rsp1_ready);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end else if (elig0 && elig1) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      grant0 = last_grant_q;
      grant1 = ~last_grant_q;
`else
      grant0 = 1'b1;
      grant1 = 1'b0;
`endif
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  // Steer the granted requester onto the shared ALU; quiet zeros when idle.
  always_comb begin
    alu_operand_a   = 32'd0;
    alu_operand_b   = 32'd0;
    alu_op          = 4'd0;
    alu_funct3      = 3'd0;
    alu_funct7_bit5 = 1'b0;
    if (grant0) begin
      alu_operand_a   = req0_a;
      alu_operand_b   = req0_b;
      alu_op          = req0_op;
      alu_funct3      = req0_funct3;
      alu_funct7_bit5 = req0_f7b5;
    end else if (grant1) begin
      alu_operand_a   = req1_a;
      alu_operand_b   = req1_b;
      alu_op          = req1_op;
      alu_funct3      = req1_funct3;
      alu_funct7_bit5 = req1_f7b5;
    end else begin
      alu_operand_a   = 32'd0;
    end
  end

  // A new accept overrides a same-cycle consume, so the valid flag never dips.
  always_comb begin
    rsp0_valid_d  = rsp0_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_zero_d   = rsp0_zero_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_zero_d   = rsp1_zero_q;
    last_grant_d  = last_grant_q;
    if (grant0) begin
      rsp0_valid_d  = 1'b1;
      rsp0_result_d = alu_result;
      rsp0_zero_d   = alu_is_zero;
      last_grant_d  = 1'b0;
    end else if (rsp0_valid_q && rsp0_ready) begin
      rsp0_valid_d  = 1'b0;
    end else begin
      rsp0_valid_d  = rsp0_valid_q;
    end
    if (grant1) begin
      rsp1_valid_d  = 1'b1;
      rsp1_result_d = alu_result;
      rsp1_zero_d   = alu_is_zero;
      last_grant_d  = 1'b1;
    end else if (rsp1_valid_q && rsp1_ready) begin
      rsp1_valid_d  = 1'b0;
    end else begin
      rsp1_valid_d  = rsp1_valid_q;
    end
  end

  // State registers; last_grant resets to 1 so round-robin starts with requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= 32'd0;
      rsp0_zero_q   <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= 32'd0;
      rsp1_zero_q   <= 1'b0;
      last_grant_q  <= 1'b1;
    end else begin
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_zero_q   <= rsp0_zero_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_zero_q   <= rsp1_zero_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_zero   = rsp1_zero_q;
  assign last_grant  = last_grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter: the bench plays the external ALU and keeps a per-requester
// response model; directed sequences cover the reset, back-pressure and arbitration cases.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [2:0]  req0_funct3, req1_funct3;
  logic        req0_f7b5, req1_f7b5;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, rsp0_zero, rsp1_zero;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_operand_a, alu_operand_b, alu_result;
  logic [3:0]  alu_op;
  logic [2:0]  alu_funct3;
  logic        alu_funct7_bit5, alu_is_zero, last_grant;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: one pending response per requester plus the last winner.
  logic        m_v[2];
  logic [31:0] m_r[2];
  logic        m_z[2];
  logic        m_last;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_funct3(req0_funct3), .req0_f7b5(req0_f7b5),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_funct3(req1_funct3), .req1_f7b5(req1_f7b5),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_op(alu_op),
    .alu_funct3(alu_funct3), .alu_funct7_bit5(alu_funct7_bit5),
    .alu_result(alu_result), .alu_is_zero(alu_is_zero), .last_grant(last_grant)
  );

  // Simple external ALU; undefined op codes return a marker value.
  function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic [2:0] f3, input logic f7);
    logic [31:0] r;
    case (op)
      4'd0:    r = f7 ? (a - b) : (a + b);
      4'd1:    r = a & b;
      4'd2:    r = a | b;
      4'd3:    r = a ^ b;
      4'd4:    r = a << b[4:0];
      4'd5:    r = a + {29'd0, f3};
      default: r = 32'hdeadbeef;
    endcase
    return {(r == 32'd0), r};
  endfunction

  always_comb {alu_is_zero, alu_result} = ref_alu(alu_operand_a, alu_operand_b, alu_op, alu_funct3, alu_funct7_bit5);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 1'b0;
      m_r[k] = 32'd0;
      m_z[k] = 1'b0;
    end
    m_last = 1'b1;
  endtask

  // Called just after a falling edge with inputs set: check this cycle, advance model, wait a cycle.
  task automatic step();
    logic [1:0]  e;
    logic [1:0]  rr;
    int          g;
    logic [32:0] res;
    logic [31:0] ea, eb;
    logic [3:0]  eop;
    logic [2:0]  ef3;
    logic        ef7;
    #1;
    if (rst) model_reset();
    rr   = {rsp1_ready, rsp0_ready};
    e[0] = req0_valid && (!m_v[0] || rr[0]);
    e[1] = req1_valid && (!m_v[1] || rr[1]);
    if (rst) g = -1;
    else if (e == 2'b11) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      g = m_last ? 0 : 1;
`else
      g = 0;
`endif
    end
    else if (e[0]) g = 0;
    else if (e[1]) g = 1;
    else g = -1;
    {ea, eb, eop, ef3, ef7} = {32'd0, 32'd0, 4'd0, 3'd0, 1'b0};
    if (g == 0) {ea, eb, eop, ef3, ef7} = {req0_a, req0_b, req0_op, req0_funct3, req0_f7b5};
    if (g == 1) {ea, eb, eop, ef3, ef7} = {req1_a, req1_b, req1_op, req1_funct3, req1_f7b5};
    check_val("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
    check_val("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
    check_val("alu_a", alu_operand_a, ea);
    check_val("alu_b", alu_operand_b, eb);
    check_val("alu_ctl", {24'd0, alu_op, alu_funct3, alu_funct7_bit5}, {24'd0, eop, ef3, ef7});
    check_val("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_v[0]});
    check_val("rsp0_result", rsp0_result, m_r[0]);
    check_val("rsp0_zero", {31'd0, rsp0_zero}, {31'd0, m_z[0]});
    check_val("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_v[1]});
    check_val("rsp1_result", rsp1_result, m_r[1]);
    check_val("rsp1_zero", {31'd0, rsp1_zero}, {31'd0, m_z[1]});
    check_val("last_grant", {31'd0, last_grant}, {31'd0, m_last});
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (g == k) begin
          res    = ref_alu(ea, eb, eop, ef3, ef7);
          m_v[k] = 1'b1;
          m_r[k] = res[31:0];
          m_z[k] = res[32];
          m_last = k[0];
        end else if (m_v[k] && rr[k]) begin
          m_v[k] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = 4'b0000;
    {req0_a, req0_b, req0_op, req0_funct3, req0_f7b5} = {32'd0, 32'd0, 4'd0, 3'd0, 1'b0};
    {req1_a, req1_b, req1_op, req1_funct3, req1_f7b5} = {32'd0, 32'd0, 4'd0, 3'd0, 1'b0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step();
    step();
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // Single add from requester 0, accepted in the first cycle out of reset.
    {req0_valid, req0_a, req0_b, req0_op, req0_f7b5} = {1'b1, 32'd5, 32'd7, 4'd0, 1'b0};
    step();
    req0_valid = 1'b0;
    check_val("r031_valid", {31'd0, rsp0_valid}, 32'd1);
    check_val("r031_result", rsp0_result, 32'd12);
    check_val("r031_zero", {31'd0, rsp0_zero}, 32'd0);
    rsp0_ready = 1'b1;
    step();

    // Both requesting continuously with both consumers ready.
    do_reset();
    {req0_valid, req1_valid, rsp0_ready, rsp1_ready} = 4'b1111;
    req0_a = 32'd1;
    req1_a = 32'd2;
    for (int i = 0; i < 6; i++) begin
      #1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      check_val("r032_g0", {31'd0, req0_ready}, {31'd0, (i % 2) == 0});
      check_val("r032_g1", {31'd0, req1_ready}, {31'd0, (i % 2) == 1});
`else
      check_val("r032_g0", {31'd0, req0_ready}, 32'd1);
      check_val("r032_g1", {31'd0, req1_ready}, 32'd0);
`endif
      step();
    end

    // Back-pressure on requester 1, then same-cycle drain and re-accept.
    do_reset();
    {req1_valid, req1_a, req1_b, req1_op, req1_f7b5} = {1'b1, 32'd40, 32'd2, 4'd0, 1'b0};
    step();
    for (int i = 0; i < 10; i++) begin
      req1_a = $urandom;
      #1;
      check_val("r033_block", {31'd0, req1_ready}, 32'd0);
      check_val("r033_hold", rsp1_result, 32'd42);
      step();
    end
    {rsp1_ready, req1_a, req1_b, req1_op, req1_f7b5} = {1'b1, 32'd9, 32'd9, 4'd0, 1'b1};
    step();
    check_val("r034_valid", {31'd0, rsp1_valid}, 32'd1);
    check_val("r034_sub", rsp1_result, 32'd0);
    check_val("r034_zero", {31'd0, rsp1_zero}, 32'd1);
    req1_op = 4'b1111;
    step();
    check_val("r034_inv", rsp1_result, 32'hdeadbeef);
    check_val("r034_invz", {31'd0, rsp1_zero}, 32'd0);

    // Asynchronous reset one cycle after an accept discards the pending result.
    do_reset();
    {req1_valid, req1_a, req1_b} = {1'b1, 32'd3, 32'd4};
    step();
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    check_val("r035_drop", {31'd0, rsp1_valid}, 32'd0);
    check_val("r035_last", {31'd0, last_grant}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      req0_valid  = ($urandom_range(0, 3) != 0);
      req1_valid  = ($urandom_range(0, 3) != 0);
      rsp0_ready  = ($urandom_range(0, 1) != 0);
      rsp1_ready  = ($urandom_range(0, 2) != 0);
      req0_b      = $urandom;
      req1_b      = $urandom;
      req0_a      = ($urandom_range(0, 3) == 0) ? req0_b : $urandom;
      req1_a      = ($urandom_range(0, 3) == 0) ? req1_b : $urandom;
      req0_op     = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      req1_op     = ($urandom_range(0, 7) == 0) ? 4'd12 : 4'($urandom_range(0, 5));
      req0_funct3 = 3'($urandom_range(0, 7));
      req1_funct3 = 3'($urandom_range(0, 7));
      req0_f7b5   = 1'($urandom_range(0, 1));
      req1_f7b5   = 1'($urandom_range(0, 1));
      rst         = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
